apc_serial_endpoint: RTL and testbench

// - Core-side endpoint of the APC bit-serial link; it is the receiving end of what the boot-control wrapper drives.
// - Deserialises a FRAME_W-bit input frame (key | block | mode | reserved), presents it in parallel to a block-cipher engine, then re-serialises the BLK_W-bit result back to boot control.
// - Sits between the boot-control wrapper and the AES engine inside the APC.

---
 rtl/apc_pkg.sv | 13 +
 rtl/apc_piso.sv | 36 +++
 rtl/apc_serial_endpoint.sv | 110 +++++++++++
 tb/tb_apc_serial_endpoint.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/apc_pkg.sv
// Shared types and frame layout for the APC bit-serial endpoint.
package apc_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, SEND} apc_ep_state_t;

  localparam int KEY_W    = 256;
  localparam int KEY_LSB  = 0;
  localparam int BLK_LSB  = 256;
  localparam int MODE_BIT = 384;
  localparam int FRAME_W  = 612;
  localparam int BLK_W    = 128;

endpackage

// File: rtl/apc_piso.sv
// Parallel-in/serial-out result shifter: LSB first, valid for exactly BLK_W cycles after load.
module apc_piso #(
  parameter int BLK_W = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [BLK_W-1:0] din,
  output logic             dout,
  output logic             dout_valid,
  output logic             last
);

  localparam int CW = $clog2(BLK_W + 1);

  logic [BLK_W-1:0] sreg;
  logic [CW-1:0]    left;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
      left <= '0;
    end else if (load) begin
      sreg <= din;
      left <= CW'(BLK_W);
    end else if (left != '0) begin
      sreg <= sreg >> 1;
      left <= left - 1'b1;
    end
  end

  assign dout_valid = (left != '0);
  assign dout       = dout_valid & sreg[0];
  assign last       = (left == CW'(1));

endmodule

// File: rtl/apc_serial_endpoint.sv
// Core-side APC serial endpoint: deserialises a frame, hands it to the cipher engine,
// and serialises the engine result back to boot control.
module apc_serial_endpoint
  import apc_pkg::*;
#(
  parameter int KEY_W    = apc_pkg::KEY_W,
  parameter int BLK_W    = apc_pkg::BLK_W,
  parameter int FRAME_W  = apc_pkg::FRAME_W,
  parameter int MODE_BIT = apc_pkg::MODE_BIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             apc_data_in,
  input  logic             apc_data_in_valid,
  input  logic             apc_word_en,
  output logic             apc_data_req,
  output logic             apc_sleep_out,
  output logic             apc_data_out,
  output logic             apc_data_out_valid,
  output logic             apc_frame_err,
  output logic [KEY_W-1:0] eng_key,
  output logic [BLK_W-1:0] eng_block,
  output logic             eng_mode,
  output logic             eng_start,
  input  logic             eng_done,
  input  logic [BLK_W-1:0] eng_result
);

  localparam int CNT_W = $clog2(FRAME_W + 1);

  apc_ep_state_t      state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [FRAME_W-1:0] frame, frame_nxt;
  logic               capture, cap_ok, good_we, bad_we, err_set;
  logic               piso_load, piso_last;
  logic               unused_reserved;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Capture happens before the word_en check, so good_we sees the post-capture count.
  always_comb begin
    frame_nxt = frame;
    cnt_nxt   = cnt;
    state_nxt = state;
    capture   = apc_data_in_valid && (state == IDLE || state == LOAD);
    cap_ok    = capture && (cnt != CNT_W'(FRAME_W));
    if (cap_ok) begin
      frame_nxt[cnt] = apc_data_in;
      cnt_nxt        = cnt + 1'b1;
    end
    good_we   = (state == LOAD) && apc_word_en && (cnt_nxt == CNT_W'(FRAME_W));
    bad_we    = (state == LOAD) && apc_word_en && !good_we;
    err_set   = bad_we || (capture && !cap_ok) ||
                (apc_data_in_valid && (state == RUN || state == SEND));
    if (good_we || bad_we) cnt_nxt = '0;
    piso_load = (state == RUN) && eng_done;

    case (state)
      IDLE: if (apc_data_in_valid) state_nxt = LOAD;
      LOAD: begin
        if (good_we)     state_nxt = RUN;
        else if (bad_we) state_nxt = IDLE;
      end
      RUN:  if (eng_done)  state_nxt = SEND;
      SEND: if (piso_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    apc_data_req  = (state == IDLE) || (state == LOAD);
    apc_sleep_out = (state == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      frame         <= '0;
      eng_key       <= '0;
      eng_block     <= '0;
      eng_mode      <= 1'b0;
      eng_start     <= 1'b0;
      apc_frame_err <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      frame     <= frame_nxt;
      eng_start <= good_we;
      if (good_we) begin
        eng_key   <= frame_nxt[KEY_W-1:0];
        eng_block <= frame_nxt[KEY_W +: BLK_W];
        eng_mode  <= frame_nxt[MODE_BIT];
      end
      if (err_set) apc_frame_err <= 1'b1;
    end
  end

  assign unused_reserved = ^frame[FRAME_W-1:MODE_BIT+1];

  apc_piso #(.BLK_W(BLK_W)) u_piso (
    .clk        (clk),
    .rst        (rst),
    .load       (piso_load),
    .din        (eng_result),
    .dout       (apc_data_out),
    .dout_valid (apc_data_out_valid),
    .last       (piso_last)
  );

endmodule

// File: tb/tb_apc_serial_endpoint.sv
// Directed bench for apc_serial_endpoint with a fixed-latency XOR engine model.
module tb_apc_serial_endpoint;

  localparam int KEY_W   = 256;
  localparam int BLK_W   = 128;
  localparam int FRAME_W = 612;

  logic             clk = 1'b0;
  logic             rst;
  logic             apc_data_in, apc_data_in_valid, apc_word_en;
  logic             apc_data_req, apc_sleep_out, apc_data_out, apc_data_out_valid, apc_frame_err;
  logic [KEY_W-1:0] eng_key;
  logic [BLK_W-1:0] eng_block;
  logic             eng_mode, eng_start, eng_done;
  logic [BLK_W-1:0] eng_result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apc_serial_endpoint #(.KEY_W(KEY_W), .BLK_W(BLK_W), .FRAME_W(FRAME_W), .MODE_BIT(384)) dut (
    .clk(clk), .rst(rst),
    .apc_data_in(apc_data_in), .apc_data_in_valid(apc_data_in_valid), .apc_word_en(apc_word_en),
    .apc_data_req(apc_data_req), .apc_sleep_out(apc_sleep_out),
    .apc_data_out(apc_data_out), .apc_data_out_valid(apc_data_out_valid),
    .apc_frame_err(apc_frame_err),
    .eng_key(eng_key), .eng_block(eng_block), .eng_mode(eng_mode), .eng_start(eng_start),
    .eng_done(eng_done), .eng_result(eng_result)
  );

  // Engine model: result = block ^ key[127:0], done pulse 5 cycles after start.
  initial begin
    logic [BLK_W-1:0] r;
    eng_done   = 1'b0;
    eng_result = '0;
    forever begin
      @(posedge clk); #1;
      if (eng_start && !rst) begin
        r = eng_block ^ eng_key[BLK_W-1:0];
        repeat (4) @(posedge clk);
        #1 eng_done = 1'b1; eng_result = r;
        @(posedge clk);
        #1 eng_done = 1'b0; eng_result = '0;
      end
    end
  end

  typedef struct {
    logic [KEY_W-1:0] key;
    logic [BLK_W-1:0] blk;
    logic             mode;
    int               nbits;
    bit               exp_start;
    bit               exp_err;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [KEY_W-1:0] act, input logic [KEY_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input logic [KEY_W-1:0] key, input logic [BLK_W-1:0] blk,
                            input logic mode, input int nbits);
    logic [FRAME_W-1:0] f;
    f = '1;
    f[255:0]   = key;
    f[383:256] = blk;
    f[384]     = mode;
    for (int i = 0; i < nbits; i++) begin
      apc_data_in_valid = 1'b1;
      apc_data_in       = (i < FRAME_W) ? f[i] : 1'b0;
      tick();
    end
    apc_data_in_valid = 1'b0;
    apc_data_in       = 1'b0;
    apc_word_en       = 1'b1;
    tick();
    apc_word_en       = 1'b0;
  endtask

  // Waits for the result, then gathers up to nbits output bits.
  task automatic collect(input int nbits, output logic [BLK_W-1:0] w,
                         output bit contig, output bit req_low);
    int n;
    w = '0; contig = 1'b1; req_low = 1'b1; n = 0;
    while (!apc_data_out_valid && n < 200) begin
      if (apc_data_req) req_low = 1'b0;
      tick();
      n++;
    end
    if (n >= 200) chk("result_timeout", 1'b0, 1'b1);
    for (int i = 0; i < nbits; i++) begin
      w[i] = apc_data_out;
      if (!apc_data_out_valid) contig = 1'b0;
      if (apc_data_req) req_low = 1'b0;
      tick();
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v, input int busy_bits);
    logic [BLK_W-1:0] w;
    bit contig, req_low;
    send_frame(v.key, v.blk, v.mode, v.nbits);
    chk({tag, "_start"}, eng_start, v.exp_start);
    if (v.exp_start) begin
      chk({tag, "_key"}, eng_key, v.key);
      chk({tag, "_block"}, eng_block, v.blk);
      chk({tag, "_mode"}, eng_mode, v.mode);
      chk({tag, "_sleep_busy"}, apc_sleep_out, 1'b0);
      for (int i = 0; i < busy_bits; i++) begin
        apc_data_in_valid = 1'b1;
        apc_data_in       = 1'b1;
        tick();
      end
      apc_data_in_valid = 1'b0;
      apc_data_in       = 1'b0;
      collect(BLK_W, w, contig, req_low);
      chk({tag, "_result"}, w, v.blk ^ v.key[BLK_W-1:0]);
      chk({tag, "_contig"}, contig, 1'b1);
      chk({tag, "_req_low"}, req_low, 1'b1);
      chk({tag, "_end_valid"}, apc_data_out_valid, 1'b0);
      chk({tag, "_end_dout"}, apc_data_out, 1'b0);
    end
    chk({tag, "_sleep_idle"}, apc_sleep_out, 1'b1);
    chk({tag, "_req_idle"}, apc_data_req, 1'b1);
    chk({tag, "_err"}, apc_frame_err, v.exp_err);
  endtask

  localparam logic [KEY_W-1:0] K0 = 256'h49361d1e_8a5f02c7_3be41d96_7c0a55f3_d2e8b417_6f93a0c2_5e1b7d48_0c13ef1b;
  localparam logic [BLK_W-1:0] B0 = 128'h01234567_89abcdef_00112233_44556677;
  localparam logic [KEY_W-1:0] K1 = 256'h00112233_44556677_8899aabb_ccddeeff_0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
  localparam logic [BLK_W-1:0] B1 = 128'hfedcba98_76543210_deadbeef_cafef00d;
  localparam logic [KEY_W-1:0] K2 = 256'ha5a5a5a5_5a5a5a5a_3c3c3c3c_c3c3c3c3_13579bdf_2468ace0_f0e1d2c3_b4a59687;
  localparam logic [BLK_W-1:0] B2 = 128'h80000000_00000000_00000000_00000001;
  localparam logic [BLK_W-1:0] CA = 128'h4150435f_43484950_5f49445f_4c4f5730;
  localparam logic [BLK_W-1:0] CB = 128'h4150435f_43484950_5f49445f_48493031;

  initial begin
    logic [BLK_W-1:0] w;
    bit contig, req_low;
    vec_t v;

    vecs[0] = '{key: K0, blk: B0, mode: 1'b0, nbits: 612, exp_start: 1'b1, exp_err: 1'b0};
    vecs[1] = '{key: K1, blk: B1, mode: 1'b1, nbits: 600, exp_start: 1'b0, exp_err: 1'b1};
    vecs[2] = '{key: K1, blk: B1, mode: 1'b1, nbits: 612, exp_start: 1'b1, exp_err: 1'b1};
    vecs[3] = '{key: K2, blk: B2, mode: 1'b0, nbits: 615, exp_start: 1'b1, exp_err: 1'b1};

    rst = 1'b1; apc_data_in = 1'b0; apc_data_in_valid = 1'b0; apc_word_en = 1'b0;
    repeat (3) tick();
    chk("rst_req", apc_data_req, 1'b1);
    chk("rst_sleep", apc_sleep_out, 1'b1);
    chk("rst_valid", apc_data_out_valid, 1'b0);
    chk("rst_err", apc_frame_err, 1'b0);
    chk("rst_start", eng_start, 1'b0);
    chk("rst_key", eng_key, '0);
    rst = 1'b0;
    tick();

    // Stray word_en in IDLE must be ignored.
    apc_word_en = 1'b1; tick(); apc_word_en = 1'b0;
    chk("idle_we_err", apc_frame_err, 1'b0);
    chk("idle_we_start", eng_start, 1'b0);

    for (int i = 0; i < 4; i++) run_vec($sformatf("vec%0d", i), vecs[i], 0);

    // Back-to-back chip-id halves: second frame starts right after the first returns to idle.
    v = '{key: K0, blk: CA, mode: 1'b0, nbits: 612, exp_start: 1'b1, exp_err: 1'b1};
    run_vec("b2b_a", v, 0);
    v = '{key: K2, blk: CB, mode: 1'b1, nbits: 612, exp_start: 1'b1, exp_err: 1'b1};
    run_vec("b2b_b", v, 0);

    // Reset mid-SEND, 40 bits into the result.
    send_frame(K1, B0, 1'b0, 612);
    chk("rs_start", eng_start, 1'b1);
    collect(40, w, contig, req_low);
    chk("rs_partial", w[39:0], B0[39:0] ^ K1[39:0]);
    chk("rs_valid_pre", apc_data_out_valid, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("rs_valid", apc_data_out_valid, 1'b0);
    chk("rs_req", apc_data_req, 1'b1);
    chk("rs_sleep", apc_sleep_out, 1'b1);
    chk("rs_err", apc_frame_err, 1'b0);
    #1 rst = 1'b0;
    tick();
    tick();
    chk("rs_quiet", apc_data_out_valid, 1'b0);

    // Valid bits while the engine is busy: ignored but flagged.
    v = '{key: K0, blk: B0, mode: 1'b1, nbits: 612, exp_start: 1'b1, exp_err: 1'b1};
    run_vec("busy", v, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
